ball_seq_ctrl: RTL

- Programmable colour-sequence controller for the ball-sorting line.
- Accepts classified ball colour codes from the sensor front end over a valid/ready handshake and matches them against a software-loaded target sequence.
- Raises a registered match pulse, counts matches, and aborts a stalled partial match on timeout.
- Replaces the fixed r-g-b detector with a configurable, start/stop-sequenced block.

---
 rtl/ball_seq_pkg.sv | 26 ++
 rtl/ball_seq_ctrl_target_regs.sv | 41 ++++
 rtl/ball_seq_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ball_seq_pkg.sv
// Shared definitions for the ball colour-sequence controller: colour codes,
// controller states and the power-on target pattern.
package ball_seq_pkg;

    localparam logic [1:0] COL_R   = 2'd0;
    localparam logic [1:0] COL_G   = 2'd1;
    localparam logic [1:0] COL_B   = 2'd2;
    localparam logic [1:0] COL_INV = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Power-on target cycles r,g,b,r,g,... along the sequence
    function automatic logic [1:0] default_color(input int idx);
        logic [1:0] col;
        case (idx % 3)
            0:       col = COL_R;
            1:       col = COL_G;
            default: col = COL_B;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/ball_seq_ctrl_target_regs.sv
// Target colour register file; writes are accepted only while the controller
// is idle so the sequence cannot change under a running match.
module ball_seq_target_regs
    import ball_seq_pkg::*;
#(
    parameter int SEQ_LEN = 3,
    parameter int COLOR_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       idle_i,
    input  logic                       wr_en_i,
    input  logic [2:0]                 wr_idx_i,
    input  logic [COLOR_W-1:0]         wr_color_i,
    output logic [SEQ_LEN*COLOR_W-1:0] target_o
);

    logic [COLOR_W-1:0] target_q [SEQ_LEN];

    // Element storage; out-of-range indices simply match no element
    always_ff @(posedge clk) begin
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (rst) begin
                target_q[i] <= COLOR_W'(default_color(i));
            end else if (wr_en_i && idle_i && (wr_idx_i == 3'(i))) begin
                target_q[i] <= wr_color_i;
            end else begin
                target_q[i] <= target_q[i];
            end
        end
    end

    // Flatten for the matcher
    always_comb begin
        target_o = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            target_o[i*COLOR_W +: COLOR_W] = target_q[i];
        end
    end

endmodule

// File: rtl/ball_seq_ctrl.sv
// Programmable colour-sequence matcher with start/stop sequencing.
// Optional stalled-match timeout is enabled by defining BALL_SEQ_TIMEOUT_EN.
module ball_seq_ctrl
    import ball_seq_pkg::*;
#(
    parameter int SEQ_LEN     = 3,
    parameter int COLOR_W     = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_idx,
    input  logic [COLOR_W-1:0] cfg_color,
    input  logic               start,
    input  logic               stop,
    input  logic               ball_valid,
    input  logic [COLOR_W-1:0] ball_color,
    output logic               ball_ready,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               timeout_err
);

    state_e                     state_q;
    logic [2:0]                 ptr_q;
    logic [2:0]                 ptr_d;
    logic [CNT_W-1:0]           match_cnt_q;
    logic                       match_q;
    logic [SEQ_LEN*COLOR_W-1:0] target_s;
    logic [COLOR_W-1:0]         cur_tgt_s;
    logic                       accept_s;
    logic                       valid_col_s;
    logic                       hit_s;
    logic                       last_s;
    logic                       expire_s;

    ball_seq_target_regs #(
        .SEQ_LEN (SEQ_LEN),
        .COLOR_W (COLOR_W)
    ) u_target (
        .clk        (clk),
        .rst        (rst),
        .idle_i     (state_q == IDLE),
        .wr_en_i    (cfg_we),
        .wr_idx_i   (cfg_idx),
        .wr_color_i (cfg_color),
        .target_o   (target_s)
    );

    assign ball_ready  = (state_q == RUN) && !stop;
    assign accept_s    = ball_valid && ball_ready;
    assign busy        = (state_q == RUN);
    assign match       = match_q;
    assign match_cnt   = match_cnt_q;

    // Select the target element the pointer is waiting on
    always_comb begin
        cur_tgt_s = target_s[COLOR_W-1:0];
        for (int i = 0; i < SEQ_LEN; i++) begin
            cur_tgt_s = (ptr_q == 3'(i)) ? target_s[i*COLOR_W +: COLOR_W] : cur_tgt_s;
        end
    end

    assign valid_col_s = (ball_color != COLOR_W'(COL_INV));
    assign hit_s       = valid_col_s && (ball_color == cur_tgt_s);
    assign last_s      = (ptr_q == 3'(SEQ_LEN - 1));

    // Next pointer; a mismatching ball may itself open a new attempt
    always_comb begin
        ptr_d = ptr_q;
        if (accept_s) begin
            if (hit_s && last_s) begin
                ptr_d = 3'd0;
            end else if (hit_s) begin
                ptr_d = ptr_q + 3'd1;
            end else if (valid_col_s && (ball_color == target_s[COLOR_W-1:0])) begin
                ptr_d = 3'd1;
            end else begin
                ptr_d = 3'd0;
            end
        end else if (expire_s) begin
            ptr_d = 3'd0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Controller FSM with pointer, match pulse and saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            match_cnt_q <= '0;
            match_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ptr_q   <= 3'd0;
                    match_q <= 1'b0;
                    if (start && !stop) begin
                        state_q     <= RUN;
                        match_cnt_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    match_q <= accept_s && hit_s && last_s;
                    if (stop) begin
                        state_q <= IDLE;
                        ptr_q   <= 3'd0;
                    end else begin
                        ptr_q <= ptr_d;
                    end
                    if (accept_s && hit_s && last_s && (match_cnt_q != {CNT_W{1'b1}})) begin
                        match_cnt_q <= match_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        match_cnt_q <= match_cnt_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= 3'd0;
                    match_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BALL_SEQ_TIMEOUT_EN
    logic [15:0] timer_q;
    logic        timeout_err_q;

    // An accepted ball on the expiry cycle wins over the timeout
    assign expire_s = (state_q == RUN) && !stop && (ptr_q != 3'd0) && !accept_s &&
                      (timer_q == 16'(TIMEOUT_CYC - 1));
    assign timeout_err = timeout_err_q;

    // Idle timer runs only while a partial match is pending
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q       <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= expire_s;
            if ((state_q == RUN) && !stop && (ptr_q != 3'd0) && !accept_s && !expire_s) begin
                timer_q <= timer_q + 16'd1;
            end else begin
                timer_q <= 16'd0;
            end
        end
    end
`else
    logic unused_timeout_s;

    // TIMEOUT_CYC only matters to the timeout path
    assign unused_timeout_s = (TIMEOUT_CYC > 0);
    assign expire_s         = 1'b0;
    assign timeout_err      = 1'b0;
`endif

endmodule
